// File: rtl/spram_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spram_pkg : shared constants for single-port RAM access controllers  |
// | Rev 1.0   : initial release                                          |
// +----------------------------------------------------------------------+
package spram_pkg;

  localparam int   RD_LATENCY = 2;
  localparam logic CLI0       = 1'b0;
  localparam logic CLI1       = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arb2 : combinational two-way round-robin grant                    |
// | Rev 1.0 : initial release                                            |
// +----------------------------------------------------------------------+
module rr_arb2
  import spram_pkg::*;
(
  input  logic i_rst_n,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  output logic o_gnt0,
  output logic o_gnt1
);

  // On contention the client that did not win last time is served.
  always_comb begin
    o_gnt0 = 1'b0;
    o_gnt1 = 1'b0;
    if (i_rst_n) begin
      if (i_req0 && (!i_req1 || (i_last == CLI1))) begin
        o_gnt0 = 1'b1;
      end else if (i_req1) begin
        o_gnt1 = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/spram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spram_arbiter : two-client round-robin front end for a single-port   |
// |                 RAM with registered address and 2-cycle read return  |
// | Rev 1.0       : initial release                                      |
// +----------------------------------------------------------------------+
module spram_arbiter
  import spram_pkg::*;
#(
  parameter int msb      = 8,
  parameter int addrsize = 8
) (
  input  logic                clka,
  input  logic                rsta_n,
  input  logic                req0,
  input  logic                we0,
  input  logic [addrsize-1:0] addr0,
  input  logic [msb-1:0]      wdata0,
  output logic                gnt0,
  output logic                rvalid0,
  output logic [msb-1:0]      rdata0,
  input  logic                req1,
  input  logic                we1,
  input  logic [addrsize-1:0] addr1,
  input  logic [msb-1:0]      wdata1,
  output logic                gnt1,
  output logic                rvalid1,
  output logic [msb-1:0]      rdata1,
  output logic                ram_wea,
  output logic [addrsize-1:0] ram_addra,
  output logic [msb-1:0]      ram_dina,
  input  logic [msb-1:0]      ram_douta
);

  logic                r_last;
  logic [addrsize-1:0] r_hold_addr;
  logic                r_s1_valid;
  logic                r_s1_owner;
  logic                r_rvalid0;
  logic                r_rvalid1;
  logic [msb-1:0]      r_rdata0;
  logic [msb-1:0]      r_rdata1;

  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_acc;
  logic                w_sel;
  logic                w_we;
  logic [addrsize-1:0] w_addr;
  logic [msb-1:0]      w_din;
  logic                w_fwd;
  logic [msb-1:0]      w_rd_data;

  rr_arb2 u_arb (
    .i_rst_n (rsta_n),
    .i_req0  (req0),
    .i_req1  (req1),
    .i_last  (r_last),
    .o_gnt0  (w_gnt0),
    .o_gnt1  (w_gnt1)
  );

  always_comb begin
    w_acc  = 1'b0;
    w_sel  = CLI0;
    w_we   = 1'b0;
    w_addr = r_hold_addr;
    w_din  = '0;
    if (req0 && w_gnt0) begin
      w_acc  = 1'b1;
      w_sel  = CLI0;
      w_we   = we0;
      w_addr = addr0;
      w_din  = wdata0;
    end else if (req1 && w_gnt1) begin
      w_acc  = 1'b1;
      w_sel  = CLI1;
      w_we   = we1;
      w_addr = addr1;
      w_din  = wdata1;
    end
  end

  // The RAM's douta still shows pre-write contents while a same-address
  // write is in progress, so forward the write data to keep write-first.
  assign w_fwd     = r_s1_valid && w_acc && w_we && (w_addr == r_hold_addr);
  assign w_rd_data = w_fwd ? w_din : ram_douta;

  always_ff @(posedge clka) begin
    if (!rsta_n) begin
      r_last      <= CLI1;
      r_hold_addr <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_owner  <= CLI0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      if (w_acc) begin
        r_last      <= w_sel;
        r_hold_addr <= w_addr;
      end
      r_s1_valid <= w_acc && !w_we;
      r_s1_owner <= w_sel;
      r_rvalid0  <= r_s1_valid && (r_s1_owner == CLI0);
      r_rvalid1  <= r_s1_valid && (r_s1_owner == CLI1);
      if (r_s1_valid && (r_s1_owner == CLI0)) begin
        r_rdata0 <= w_rd_data;
      end
      if (r_s1_valid && (r_s1_owner == CLI1)) begin
        r_rdata1 <= w_rd_data;
      end
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign rvalid0   = r_rvalid0;
  assign rvalid1   = r_rvalid1;
  assign rdata0    = r_rdata0;
  assign rdata1    = r_rdata1;
  assign ram_wea   = w_we;
  assign ram_addra = w_addr;
  assign ram_dina  = w_din;

endmodule
`default_nettype wire
